// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_TIMEOUT    = 1000;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Place byte b at big-endian lane idx (lane 0 = most significant byte).
    function automatic logic [WORD_W-1:0] insert_byte(
        input logic [WORD_W-1:0]     word,
        input logic [BYTE_IDX_W-1:0] idx,
        input logic [7:0]            b
    );
        logic [WORD_W-1:0] r;
        r = word;
        for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
            if (idx == BYTE_IDX_W'(k)) begin
                r[WORD_W-1-8*k -: 8] = b;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer; flags the byte that completes a word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [7:0]        byte_i,
    output logic              word_valid_c,
    output logic [WORD_W-1:0] word_c
);

    logic [BYTE_IDX_W-1:0] idx_q;
    logic [BYTE_IDX_W-1:0] idx_d;
    logic [WORD_W-1:0]     shift_q;

    // The completed word is presented in the same cycle as its last byte.
    always_comb begin
        word_c       = insert_byte(shift_q, idx_q, byte_i);
        word_valid_c = byte_en_i && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
        idx_d        = idx_q + BYTE_IDX_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else if (clear_i) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else if (byte_en_i) begin
            idx_q   <= idx_d;
            shift_q <= word_c;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into words, writes them from address 0
// and holds the core in reset until a complete load has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_W-1:0]     imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [WORD_W-1:0]     checksum
);

    localparam int unsigned NW_W  = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    state_e                state_q;
    logic [NW_W-1:0]       num_words_q;
    logic [ADDR_WIDTH-1:0] word_cnt_q;
    logic [ADDR_WIDTH-1:0] word_cnt_d;
    logic [TO_W-1:0]       idle_cnt_q;
    logic [TO_W-1:0]       idle_cnt_d;
    logic                  byte_ready_q;
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [WORD_W-1:0]     imem_wdata_q;
    logic                  cpu_reset_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [WORD_W-1:0]     checksum_q;

    logic                  start_ok_c;
    logic                  load_c;
    logic                  byte_acc_c;
    logic                  last_word_c;
    logic                  idle_expired_c;
    logic                  word_valid_c;
    logic [WORD_W-1:0]     word_c;

    always_comb begin
        start_ok_c     = (num_words != '0) && (num_words <= NW_W'(DEPTH));
        load_c         = start && start_ok_c && (state_q == ST_IDLE);
        byte_acc_c     = byte_valid && byte_ready_q;
        last_word_c    = ({1'b0, word_cnt_q} == (num_words_q - NW_W'(1)));
        idle_expired_c = (idle_cnt_q == TO_W'(TIMEOUT - 1));
        word_cnt_d     = word_cnt_q + ADDR_WIDTH'(1);
        idle_cnt_d     = idle_cnt_q + TO_W'(1);
    end

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (load_c),
        .byte_en_i    (byte_acc_c),
        .byte_i       (byte_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            num_words_q  <= '0;
            word_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            checksum_q   <= '0;
        end else begin
            imem_we_q <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (start_ok_c) begin
                            num_words_q  <= num_words;
                            word_cnt_q   <= '0;
                            idle_cnt_q   <= '0;
                            checksum_q   <= '0;
                            error_q      <= 1'b0;
                            cpu_reset_q  <= 1'b1;
                            byte_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= ST_RECV;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (word_valid_c) begin
                        byte_ready_q <= 1'b0;
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= word_cnt_q;
                        imem_wdata_q <= word_c;
                        state_q      <= ST_WRITE;
                    end else if (byte_acc_c) begin
                        idle_cnt_q <= '0;
                    end else if (idle_expired_c) begin
                        // Abort: the core stays in reset, memory contents are partial.
                        error_q      <= 1'b1;
                        byte_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end
                ST_WRITE: begin
                    checksum_q <= checksum_q ^ imem_wdata_q;
                    idle_cnt_q <= '0;
                    if (last_word_c) begin
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_DONE;
                    end else begin
                        word_cnt_q   <= word_cnt_d;
                        byte_ready_q <= 1'b1;
                        state_q      <= ST_RECV;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: drivers queue expected writes/done events,
// a negedge monitor pops and compares them as the loader produces them.
module tb_imem_loader;

    localparam int AW      = 10;
    localparam int TIMEOUT = 1000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   num_words = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [31:0]   checksum;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [AW-1:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe and every done pulse must match the next queued event.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                check("we_expected", (exp_q.size() > 0 && !exp_q[0].is_done), 1);
                if (exp_q.size() > 0 && !exp_q[0].is_done) begin
                    check("we_addr", imem_addr, exp_q[0].addr);
                    check("we_data", imem_wdata, exp_q[0].data);
                    check("we_latency", cyc, exp_q[0].cyc);
                    check("we_cpu_reset", cpu_reset, 1);
                    void'(exp_q.pop_front());
                end
            end
            if (done) begin
                check("done_expected", (exp_q.size() > 0 && exp_q[0].is_done), 1);
                if (exp_q.size() > 0 && exp_q[0].is_done) begin
                    check("done_checksum", checksum, exp_q[0].data);
                    check("done_latency", cyc, exp_q[0].cyc);
                    check("done_cpu_reset", cpu_reset, 0);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // All driver tasks are entered and left at posedge + 1.
    task automatic start_load(input int n);
        num_words = (AW+1)'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc, output bit ok);
        byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        acc_cyc = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                acc_cyc = cyc;
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        check("byte_accepted", ok, 1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Reference: word i = bytes 4i..4i+3, first byte most significant; checksum = XOR of words.
    task automatic do_load(input logic [7:0] bytes[$], input int max_gap);
        int   n;
        int   acc;
        bit   ok;
        logic [31:0] w;
        logic [31:0] cks;
        exp_t e;
        n   = bytes.size() / 4;
        cks = 32'h0;
        acc = 0;
        start_load(n);
        check("start_error_clr", error, 0);
        check("start_cpu_reset", cpu_reset, 1);
        check("start_busy", busy, 1);
        for (int i = 0; i < n; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                w = (w << 8) | 32'(bytes[4*i+k]);
                send_byte(bytes[4*i+k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, acc, ok);
                if (!ok) return;
            end
            cks = cks ^ w;
            e.is_done = 1'b0; e.addr = AW'(i); e.data = w; e.cyc = acc + 1;
            exp_q.push_back(e);
        end
        e.is_done = 1'b1; e.addr = '0; e.data = cks; e.cyc = acc + 2;
        exp_q.push_back(e);
        wait_drain();
        check("end_done_low", done, 0);
        check("end_cpu_reset", cpu_reset, 0);
        check("end_busy", busy, 0);
    endtask

    task automatic rand_bytes(input int n_words, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < 4 * n_words; i++) q.push_back(8'($urandom));
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bq[$];
        logic       prev;
        int         acc;
        bit         ok;

        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_ready", byte_ready, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_checksum", checksum, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed two-word load.
        bq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_load(bq, 0);
        check("directed_checksum", checksum, 32'hB88F9AA5);

        // Three-word loads with random byte_valid gaps.
        for (int r = 0; r < 3; r++) begin
            rand_bytes(3, bq);
            do_load(bq, 12);
        end

        // Illegal word counts, with stray byte_valid while idle.
        prev = cpu_reset;
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        start_load(0);
        check("nw0_error", error, 1);
        check("nw0_busy", busy, 0);
        check("nw0_byte_ready", byte_ready, 0);
        check("nw0_cpu_reset", cpu_reset, prev);
        start_load(1025);
        check("nw1025_error", error, 1);
        check("nw1025_busy", busy, 0);
        check("nw1025_cpu_reset", cpu_reset, prev);
        repeat (3) begin @(posedge clk); #1; end
        byte_valid = 1'b0;
        check("nw_idle_no_ready", byte_ready, 0);
        rand_bytes(2, bq);
        do_load(bq, 3);

        // Stall after two bytes of word 0 until the idle timeout fires.
        start_load(2);
        send_byte(8'h11, 0, acc, ok);
        send_byte(8'h22, 0, acc, ok);
        repeat (TIMEOUT - 5) begin @(posedge clk); #1; end
        check("to_not_early", busy, 1);
        repeat (10) begin @(posedge clk); #1; end
        check("to_error", error, 1);
        check("to_busy", busy, 0);
        check("to_byte_ready", byte_ready, 0);
        check("to_cpu_reset", cpu_reset, 1);
        check("to_no_write", exp_q.size(), 0);
        rand_bytes(3, bq);
        do_load(bq, 5);

        // Full-depth load: last write at the all-ones address.
        rand_bytes(1024, bq);
        do_load(bq, 0);

        // Asynchronous reset during the WRITE cycle.
        start_load(2);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom), 0, acc, ok);
        check("wr_we_seen", imem_we, 1);
        reset = 1'b1;
        #1;
        check("arst_imem_we", imem_we, 0);
        check("arst_imem_addr", imem_addr, 0);
        check("arst_imem_wdata", imem_wdata, 0);
        check("arst_busy", busy, 0);
        check("arst_byte_ready", byte_ready, 0);
        check("arst_checksum", checksum, 0);
        check("arst_cpu_reset", cpu_reset, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        rand_bytes(2, bq);
        do_load(bq, 4);

        repeat (5) begin @(posedge clk); #1; end
        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
